// File: rtl/gpu_pkg.sv
// Shared GPU core definitions: core state encodings, write-back source codes
// and the special register indices used by each thread lane.
package gpu_pkg;

  typedef enum logic [2:0] {
    CORE_IDLE    = 3'b000,
    CORE_FETCH   = 3'b001,
    CORE_DECODE  = 3'b010,
    CORE_REQUEST = 3'b011,
    CORE_WAIT    = 3'b100,
    CORE_EXECUTE = 3'b101,
    CORE_UPDATE  = 3'b110,
    CORE_DONE    = 3'b111
  } core_state_t;

  localparam logic [1:0] REG_SRC_ALU = 2'b00;
  localparam logic [1:0] REG_SRC_LSU = 2'b01;
  localparam logic [1:0] REG_SRC_IMM = 2'b10;

  localparam logic [3:0] NUM_GPR        = 4'd13;
  localparam logic [3:0] REG_BLOCK_IDX  = 4'd13;
  localparam logic [3:0] REG_BLOCK_DIM  = 4'd14;
  localparam logic [3:0] REG_THREAD_IDX = 4'd15;

endpackage

// File: rtl/register_file_if.sv
// Decoder/ALU/LSU-facing bus of one thread's register file; the master side
// drives the decoded instruction fields and results, the slave returns operands.
interface register_file_if #(
  parameter int DATA_BITS = 8
);
  import gpu_pkg::*;

  logic                 enable;
  logic [7:0]           block_id;
  core_state_t          core_state;
  logic [3:0]           decoded_rd;
  logic [3:0]           decoded_rs;
  logic [3:0]           decoded_rt;
  logic                 decoded_reg_write_enable;
  logic [1:0]           decoded_reg_input_mux;
  logic [DATA_BITS-1:0] decoded_immediate;
  logic [DATA_BITS-1:0] alu_out;
  logic [DATA_BITS-1:0] lsu_out;
  logic [DATA_BITS-1:0] rs_out;
  logic [DATA_BITS-1:0] rt_out;

  modport master (
    output enable, block_id, core_state,
    output decoded_rd, decoded_rs, decoded_rt,
    output decoded_reg_write_enable, decoded_reg_input_mux, decoded_immediate,
    output alu_out, lsu_out,
    input  rs_out, rt_out
  );

  modport slave (
    input  enable, block_id, core_state,
    input  decoded_rd, decoded_rs, decoded_rt,
    input  decoded_reg_write_enable, decoded_reg_input_mux, decoded_immediate,
    input  alu_out, lsu_out,
    output rs_out, rt_out
  );

endinterface

// File: rtl/reg_wb_mux.sv
// Combinational write-back select: picks ALU, LSU or immediate data and flags
// whether the write may land (never for the reserved code or special registers).
module reg_wb_mux
  import gpu_pkg::*;
#(
  parameter int DATA_BITS = 8
) (
  input  logic                 reg_write_enable,
  input  logic [1:0]           reg_input_mux,
  input  logic [3:0]           rd,
  input  logic [DATA_BITS-1:0] alu_out,
  input  logic [DATA_BITS-1:0] lsu_out,
  input  logic [DATA_BITS-1:0] immediate,
  output logic [DATA_BITS-1:0] wb_data,
  output logic                 wb_valid
);

  logic src_valid;

  always_comb begin
    wb_data   = '0;
    src_valid = 1'b0;
    case (reg_input_mux)
      REG_SRC_ALU: begin
        wb_data   = alu_out;
        src_valid = 1'b1;
      end
      REG_SRC_LSU: begin
        wb_data   = lsu_out;
        src_valid = 1'b1;
      end
      REG_SRC_IMM: begin
        wb_data   = immediate;
        src_valid = 1'b1;
      end
      default: begin
        wb_data   = '0;
        src_valid = 1'b0;
      end
    endcase
  end

  assign wb_valid = reg_write_enable && src_valid && (rd < NUM_GPR);

endmodule

// File: rtl/register_file.sv
// Per-thread register file: 13 general registers plus block index, block
// dimension and thread index specials; operands latched in REQUEST, written in UPDATE.
module register_file
  import gpu_pkg::*;
#(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int THREAD_ID         = 0,
  parameter int DATA_BITS         = 8
) (
  input logic            clock,
  input logic            reset_n,
  register_file_if.slave rf
);

  logic [DATA_BITS-1:0] gpr [13];
  logic [DATA_BITS-1:0] block_reg;
  logic [DATA_BITS-1:0] rs_q;
  logic [DATA_BITS-1:0] rt_q;
  logic [DATA_BITS-1:0] view [16];
  logic [DATA_BITS-1:0] wb_data;
  logic                 wb_valid;

  reg_wb_mux #(.DATA_BITS(DATA_BITS)) u_wb_mux (
    .reg_write_enable (rf.decoded_reg_write_enable),
    .reg_input_mux    (rf.decoded_reg_input_mux),
    .rd               (rf.decoded_rd),
    .alu_out          (rf.alu_out),
    .lsu_out          (rf.lsu_out),
    .immediate        (rf.decoded_immediate),
    .wb_data          (wb_data),
    .wb_valid         (wb_valid)
  );

  // Flat 16-entry read view; R14/R15 are constants so they cost no flops.
  always_comb begin
    for (int i = 0; i < 16; i++) view[i] = '0;
    for (int i = 0; i < int'(NUM_GPR); i++) view[i] = gpr[i];
    view[REG_BLOCK_IDX]  = block_reg;
    view[REG_BLOCK_DIM]  = DATA_BITS'(THREADS_PER_BLOCK);
    view[REG_THREAD_IDX] = DATA_BITS'(THREAD_ID);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(NUM_GPR); i++) gpr[i] <= '0;
      block_reg <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
    end else if (rf.enable) begin
      block_reg <= DATA_BITS'(rf.block_id);
      if (rf.core_state == CORE_REQUEST) begin
        rs_q <= view[rf.decoded_rs];
        rt_q <= view[rf.decoded_rt];
      end
      if (rf.core_state == CORE_UPDATE && wb_valid) begin
        for (int i = 0; i < int'(NUM_GPR); i++) begin
          if (rf.decoded_rd == 4'(i)) gpr[i] <= wb_data;
        end
      end
    end
  end

  assign rf.rs_out = rs_q;
  assign rf.rt_out = rt_q;

endmodule

// File: doc/register_file.md
# register_file

Per-thread register file for one SIMT thread lane: sixteen 8-bit registers, thirteen general purpose (R0–R12) and three read-only special registers (R13 = block index, R14 = block dimension, R15 = thread index). It sits directly upstream and downstream of the thread's ALU and LSU. In the REQUEST core state it registers `rs`/`rt` onto the `operand_1`/`operand_2` lines. In the UPDATE core state it writes back the ALU result, LSU result or decoded immediate. All activity is gated by the thread `enable`, and is sequenced entirely by the shared `core_state` bus.

## Interface
Parameters:
- `THREADS_PER_BLOCK`, 4 — constant held in R14.
- `THREAD_ID`, 0 — constant held in R15, unique per lane.
- `DATA_BITS`, 8 — register and datapath width.

Ports:
- `clock` in 1 — single clock; all state changes on rising edge.
- `reset_n` in 1 — asynchronous, active-low reset.
- `enable` in 1 — thread active in current block; when low, no register or output changes occur.
- `block_id` in 8 — index of the block currently dispatched to the core.
- `core_state` in 3 — shared core state bus.
- `decoded_rd` in 4 — destination register index.
- `decoded_rs` in 4 — first source register index.
- `decoded_rt` in 4 — second source register index.
- `decoded_reg_write_enable` in 1 — instruction writes `rd`.
- `decoded_reg_input_mux` in 2 — write-back source select.
- `decoded_immediate` in 8 — constant for CONST.
- `alu_out` in 8 — ALU result.
- `lsu_out` in 8 — load result.
- `rs_out` out 8 — registered `rs` value; drives ALU `operand_1`.
- `rt_out` out 8 — registered `rt` value; drives ALU `operand_2`.

## Operation
- Core state encodings: IDLE 000, FETCH 001, DECODE 010, REQUEST 011, WAIT 100, EXECUTE 101, UPDATE 110, DONE 111.
- Reset (`reset_n` low, asynchronous):
  - R0–R12 = 0, R13 = 0.
  - R14 = `THREADS_PER_BLOCK`, R15 = `THREAD_ID`.
  - `rs_out` = `rt_out` = 0.
- R13 tracking: R13 ← `block_id` on every rising edge while `enable` is high, independent of `core_state`.
- REQUEST, `enable` high: `rs_out` ← reg[`decoded_rs`], `rt_out` ← reg[`decoded_rt`]. Reads of R13–R15 return their special values.
- UPDATE, `enable` high and `decoded_reg_write_enable` high and `decoded_rd` < 13: reg[`decoded_rd`] ← source selected by `decoded_reg_input_mux`:
  - 00 → `alu_out`
  - 01 → `lsu_out`
  - 10 → `decoded_immediate`
  - 11 → no write (reserved)
- Writes with `decoded_rd` ≥ 13 are silently dropped. R14 and R15 never change after reset.
- In all other states the registers and `rs_out`/`rt_out` hold.
- No bypass logic: sources are only read in REQUEST and destinations only written in UPDATE, so hazards cannot occur within one instruction.
- Values are stored as unsigned 8-bit patterns. Signedness is interpreted only by the ALU.

## Timing
- Read latency: `rs_out`/`rt_out` valid on the edge that ends the REQUEST cycle. They hold through WAIT, EXECUTE and UPDATE, so the ALU samples stable operands in EXECUTE.
- Write latency: the register updates on the edge ending the UPDATE cycle. A read in the next instruction's REQUEST sees the new value.
- `enable` low: the register array, R13 and outputs hold their values; no state is disturbed.
- Reset mid-instruction: asynchronous clear takes effect immediately. The first edge after deassertion follows the normal rules for the current `core_state`.
- `decoded_rs` == `decoded_rt`: both outputs carry the same value.
- An index of 0 is an ordinary writable register; R0 is not hardwired to zero.

## Structure
- Shared package `gpu_pkg`:
  - `core_state` encodings (IDLE…DONE).
  - write-back mux codes: `REG_SRC_ALU` = 00, `REG_SRC_LSU` = 01, `REG_SRC_IMM` = 10.
  - special register indices: 13, 14, 15.
- One sub-module is natural: `reg_wb_mux`, a combinational 3:1 write-back select with a write-valid output (low for code 11 or `rd` ≥ 13).
- The storage array and read ports live in `register_file`.

## Test plan
- Reset with `THREAD_ID`=2, `THREADS_PER_BLOCK`=4, then REQUEST with rs=14, rt=15 → `rs_out`=4, `rt_out`=2. REQUEST with rs=3 → `rs_out`=0.
- CONST: UPDATE with rd=5, mux=10, imm=0x2A, then REQUEST rs=5 → `rs_out`=0x2A. Repeat with `enable`=0 → R5 unchanged.
- ALU and load write-back:
  - UPDATE rd=1, mux=00, `alu_out`=0xF3 → R1=0xF3.
  - UPDATE rd=2, mux=01, `lsu_out`=0x07 → R2=0x07.
  - REQUEST rs=1, rt=2 → `rs_out`=0xF3, `rt_out`=0x07.
- Protected registers:
  - UPDATE rd=15, imm=0x99 → R15 stays 2.
  - `block_id`=6 for one enabled edge → R13 reads 6.
  - mux=11 to rd=4 → R4 unchanged.
- Operand hold: after REQUEST, change `decoded_rs` and R-values during WAIT/EXECUTE → `rs_out`/`rt_out` unchanged until the next REQUEST.
- Reset mid-UPDATE: assert `reset_n` low between edges → all outputs 0 immediately, and R14/R15 restored to their parameter values.
